// File: rtl/clock_enable_ctrl.sv
// Run/halt/single-step timebase sequencer: emits a registered one-cycle clock-enable
// pulse every div_eff cycles while running, or exactly once per step request.
module clock_enable_ctrl #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter int unsigned TICK_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  cfg_load,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  step,
    output logic                  ce,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  cfg_err,
    output logic [TICK_WIDTH-1:0] tick_count
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10
    } state_e;

    localparam logic [DIV_WIDTH-1:0] ResetDiv =
        (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  ce_q, ce_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [TICK_WIDTH-1:0] tick_q, tick_d;

    logic [DIV_WIDTH-1:0]  div_eff;
    logic                  terminal;

    // A zero ratio would never reach its terminal count, so treat it as 1.
    assign div_eff  = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
    assign terminal = (cnt_q == div_eff - DIV_WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        ce_d      = 1'b0;
        cfg_err_d = 1'b0;
        tick_d    = ce_q ? tick_q + TICK_WIDTH'(1) : tick_q;

        if (cfg_load) begin
            if (state_q == StIdle) begin
                div_d = div;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (halt) begin
                    state_d = StIdle;
                end else if (run) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt || !run) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d = '0;
                    ce_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            StStep: begin
                if (halt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (terminal) begin
                    // The single pulse and the return to idle share one edge.
                    state_d = StIdle;
                    cnt_d   = '0;
                    ce_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= ResetDiv;
            ce_q      <= 1'b0;
            cfg_err_q <= 1'b0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            ce_q      <= ce_d;
            cfg_err_q <= cfg_err_d;
            tick_q    <= tick_d;
        end
    end

    assign ce         = ce_q;
    assign state      = state_q;
    assign busy       = (state_q != StIdle);
    assign cfg_err    = cfg_err_q;
    assign tick_count = tick_q;

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Directed bench for clock_enable_ctrl: a per-cycle vector table plus hand-written
// sequences for reset mid-run and tick counter wrap (via a narrow-counter instance).
module tb_clock_enable_ctrl;

    logic       clk = 1'b0;
    logic       reset, cfg_load, run, halt, step;
    logic [7:0] div;

    logic        ce, busy, cfg_err;
    logic [1:0]  state;
    logic [15:0] tick_count;

    logic        ce_s, busy_s, cfg_err_s;
    logic [1:0]  state_s;
    logic [3:0]  tick_s;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    clock_enable_ctrl #(.DIV_WIDTH(8), .DEFAULT_DIV(1), .TICK_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .div(div), .cfg_load(cfg_load), .run(run), .halt(halt),
        .step(step), .ce(ce), .state(state), .busy(busy), .cfg_err(cfg_err),
        .tick_count(tick_count)
    );

    clock_enable_ctrl #(.DIV_WIDTH(8), .DEFAULT_DIV(1), .TICK_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset), .div(div), .cfg_load(cfg_load), .run(run), .halt(halt),
        .step(step), .ce(ce_s), .state(state_s), .busy(busy_s), .cfg_err(cfg_err_s),
        .tick_count(tick_s)
    );

    typedef struct {
        logic       rst;
        logic       cfg;
        logic [7:0] dv;
        logic       run;
        logic       halt;
        logic       step;
        logic       ce;
        logic [1:0] st;
        logic       err;
        int         tick;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic cfg, input logic [7:0] dv,
                                input logic r, input logic h, input logic s,
                                input logic e_ce, input logic [1:0] e_st,
                                input logic e_err, input int e_tick);
        vec_t v;
        v.rst = rst; v.cfg = cfg; v.dv = dv; v.run = r; v.halt = h; v.step = s;
        v.ce = e_ce; v.st = e_st; v.err = e_err; v.tick = e_tick;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic cfg, input logic [7:0] dv,
                         input logic r, input logic h, input logic s);
        reset = rst; cfg_load = cfg; div = dv; run = r; halt = h; step = s;
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Free run at the default ratio of 1: ce from the second RUN cycle on
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) add(0, 0, 0, 1, 0, 0, 1, 1, 0, k);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
        // Ratio 4: first ce four cycles after entry, period 4; step ignored in RUN
        add(0, 1, 4, 0, 0, 0, 0, 0, 0, 10);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 10);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 3; r++) add(0, 0, 0, 1, 0, (p == 0 && r == 0), 0, 1, 0, 10 + p);
            add(0, 0, 0, 1, 0, 0, 1, 1, 0, 10 + p);
        end
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 12);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        // Ratio 3 single steps; run/step during STEP ignored
        add(0, 1, 3, 0, 0, 0, 0, 0, 0, 12);
        for (int j = 0; j < 5; j++) begin
            add(0, 0, 0, 0, 0, 1, 0, 2, 0, 12 + j);
            add(0, 0, 0, 1, 0, 1, 0, 2, 0, 12 + j);
            add(0, 0, 0, 0, 0, 0, 0, 2, 0, 12 + j);
            add(0, 0, 0, 0, 0, 0, 1, 0, 0, 12 + j);
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13 + j);
        end
        // Ratio 0 acts as 1; cfg_load in RUN rejected and period unchanged
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 17);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 17);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0, 17);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0, 18);
        add(0, 1, 5, 1, 0, 0, 1, 1, 1, 19);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0, 20);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 21);
        // halt beats run/step in IDLE; halt aborts STEP at cnt=1 of ratio 4
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 21);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 21);
        add(0, 1, 4, 0, 0, 0, 0, 0, 0, 21);
        add(0, 0, 0, 0, 0, 1, 0, 2, 0, 21);
        add(0, 1, 9, 0, 0, 0, 0, 2, 1, 21);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 21);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 21);
        // Ratio still 4 after the rejected load; halt in RUN drops to IDLE
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 21);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 21);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 21);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 21);
        add(0, 0, 0, 1, 0, 0, 1, 1, 0, 21);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 22);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 22);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].cfg, vecs[i].dv, vecs[i].run, vecs[i].halt,
                  vecs[i].step);
            tick_edge();
            check("ce", i, int'(ce), int'(vecs[i].ce));
            check("state", i, int'(state), int'(vecs[i].st));
            check("busy", i, int'(busy), int'(vecs[i].st != 2'b00));
            check("cfg_err", i, int'(cfg_err), int'(vecs[i].err));
            check("tick_count", i, int'(tick_count), vecs[i].tick);
        end

        // Reset mid-RUN at cnt=2 of ratio 4, with a cfg_load that must be ignored
        drive(0, 0, 0, 1, 0, 0);
        repeat (3) tick_edge();
        check("pre_reset_state", 0, int'(state), 1);
        check("pre_reset_ce", 0, int'(ce), 0);
        drive(1, 1, 8'd7, 1, 0, 0);
        tick_edge();
        check("rst_state", 0, int'(state), 0);
        check("rst_ce", 0, int'(ce), 0);
        check("rst_busy", 0, int'(busy), 0);
        check("rst_cfg_err", 0, int'(cfg_err), 0);
        check("rst_tick", 0, int'(tick_count), 0);
        check("rst_tick_small", 0, int'(tick_s), 0);

        // Ratio back to the default of 1 after reset
        drive(0, 0, 0, 1, 0, 0);
        tick_edge();
        check("post_rst_entry_ce", 0, int'(ce), 0);
        tick_edge();
        check("post_rst_first_ce", 0, int'(ce), 1);

        // Narrow counter wraps from all-ones to zero
        repeat (15) tick_edge();
        check("wrap_pre_small", 0, int'(tick_s), 15);
        tick_edge();
        check("wrap_small", 0, int'(tick_s), 0);
        check("wrap_wide", 0, int'(tick_count), 16);
        drive(0, 0, 0, 0, 0, 0);
        tick_edge();
        check("final_state", 0, int'(state), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
